// File: rtl/scan_select_sequencer_pkg.sv
// ============================================================================
// Module : scan_select_sequencer_pkg
// Brief  : Shared state encoding and channel count for the scan sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package scan_select_sequencer_pkg;

  localparam int NUM_CH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Searching "after channel 7" circularly starts the scan at channel 0.
  localparam logic [2:0] C_START_CUR = 3'd7;

endpackage

`default_nettype wire

// File: rtl/scan_next_finder.sv
// ============================================================================
// Module : scan_next_finder
// Brief  : Circular priority search for the first enabled channel after cur.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module scan_next_finder
  import scan_select_sequencer_pkg::*;
(
  input  logic [7:0] mask,
  input  logic [2:0] cur,
  output logic [2:0] nxt,
  output logic       wrapped,
  output logic       none
);

  logic       w_found;
  logic [2:0] w_idx;

  // Offsets 1..8 visit every channel once, ending on cur itself.
  always_comb begin
    nxt     = cur;
    w_found = 1'b0;
    w_idx   = cur;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = cur + 3'(i);
      if (!w_found && mask[w_idx]) begin
        nxt     = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign wrapped = (nxt <= cur);
  assign none    = (mask == 8'h00);

endmodule

`default_nettype wire

// File: rtl/scan_select_sequencer.sv
// ============================================================================
// Module : scan_select_sequencer
// Brief  : Masked ascending channel scanner driving a 3-to-8 decoder select.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module scan_select_sequencer
  import scan_select_sequencer_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_cont,
  input  logic [7:0] chan_mask,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic       sel_valid,
  output logic       step_pulse,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           r_state, w_state;
  logic [2:0]       r_sel, w_sel;
  logic             r_valid, w_valid;
  logic             r_step, w_step;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [7:0]       r_mask, w_mask;
  logic             r_mode, w_mode;

  logic [7:0]       w_find_mask;
  logic [2:0]       w_find_cur;
  logic [2:0]       w_nxt;
  logic             w_wrapped;
  logic             w_none;

  // In IDLE the finder looks at the live mask to pick the first channel.
  assign w_find_mask = (r_state == ST_IDLE) ? chan_mask : r_mask;
  assign w_find_cur  = (r_state == ST_IDLE) ? C_START_CUR : r_sel;

  scan_next_finder u_finder (
    .mask    (w_find_mask),
    .cur     (w_find_cur),
    .nxt     (w_nxt),
    .wrapped (w_wrapped),
    .none    (w_none)
  );

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_valid = r_valid;
    w_step  = 1'b0;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_cnt   = r_cnt;
    w_mask  = r_mask;
    w_mode  = r_mode;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_mask = chan_mask;
          w_mode = mode_cont;
          w_cnt  = '0;
          if (w_none) begin
            w_state = ST_FIN;
            w_done  = 1'b1;
          end else begin
            w_state = ST_SCAN;
            w_sel   = w_nxt;
            w_valid = 1'b1;
            w_step  = 1'b1;
            w_busy  = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (stop) begin
          w_state = ST_IDLE;
          w_sel   = 3'd0;
          w_valid = 1'b0;
          w_busy  = 1'b0;
          w_cnt   = '0;
        end else if (r_cnt == C_LAST) begin
          w_cnt = '0;
          if (w_wrapped && !r_mode) begin
            w_state = ST_FIN;
            w_sel   = 3'd0;
            w_valid = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_sel  = w_nxt;
            w_step = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_FIN: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
        w_sel   = 3'd0;
        w_valid = 1'b0;
        w_busy  = 1'b0;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 3'd0;
      r_valid <= 1'b0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_mask  <= 8'h00;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_valid <= w_valid;
      r_step  <= w_step;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_cnt   <= w_cnt;
      r_mask  <= w_mask;
      r_mode  <= w_mode;
    end
  end

  assign {s2, s1, s0} = r_sel;
  assign sel_valid    = r_valid;
  assign step_pulse   = r_step;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_scan_select_sequencer.sv
// ============================================================================
// Module : tb_scan_select_sequencer
// Brief  : Randomized self-checking bench for dwell-4 and dwell-1 sequencers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_scan_select_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start1;
  logic       stop;
  logic       mode_cont;
  logic [7:0] chan_mask;

  logic a_s2, a_s1, a_s0, a_valid, a_step, a_busy, a_done;
  logic b_s2, b_s1, b_s0, b_valid, b_step, b_busy, b_done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  scan_select_sequencer #(.DWELL_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop(stop), .mode_cont(mode_cont),
    .chan_mask(chan_mask), .s2(a_s2), .s1(a_s1), .s0(a_s0), .sel_valid(a_valid),
    .step_pulse(a_step), .busy(a_busy), .done(a_done)
  );

  scan_select_sequencer #(.DWELL_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop), .mode_cont(mode_cont),
    .chan_mask(chan_mask), .s2(b_s2), .s1(b_s1), .s0(b_s0), .sel_valid(b_valid),
    .step_pulse(b_step), .busy(b_busy), .done(b_done)
  );

  // Observation word: {sel[2:0], sel_valid, step_pulse, busy, done}
  function automatic logic [6:0] obs(input bit d1);
    return d1 ? {b_s2, b_s1, b_s0, b_valid, b_step, b_busy, b_done}
              : {a_s2, a_s1, a_s0, a_valid, a_step, a_busy, a_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit d1, input logic v);
    if (d1) start1 = v;
    else    start4 = v;
  endtask

  // Expected trace: each enabled channel in ascending order for `dwell`
  // cycles, then a done cycle (single-shot) and an idle cycle.
  task automatic run_pass(input bit d1, input logic [7:0] mask, input bit cont,
                          input string name);
    logic [6:0] exp_q[$];
    int         ch_q[$];
    int         dw;
    int         reps;
    logic [6:0] o;
    dw   = d1 ? 1 : 4;
    reps = cont ? 3 : 1;
    for (int c = 0; c < 8; c++) if (mask[c]) ch_q.push_back(c);
    if (ch_q.size() == 0) begin
      exp_q.push_back(7'b000_0001);
    end else begin
      for (int r = 0; r < reps; r++)
        foreach (ch_q[i])
          for (int j = 0; j < dw; j++)
            exp_q.push_back({3'(ch_q[i]), 1'b1, (j == 0), 1'b1, 1'b0});
      if (!cont) exp_q.push_back(7'b000_0001);
    end
    if (!cont || ch_q.size() == 0) exp_q.push_back(7'b0);

    chan_mask = mask;
    mode_cont = cont;
    stop      = 1'b0;
    set_start(d1, 1'b1);
    foreach (exp_q[k]) begin
      tick();
      o = obs(d1);
      n_total++;
      if (o !== exp_q[k]) begin
        $display("FAIL %s cycle %0d: got %b want %b", name, k, o, exp_q[k]);
      end else begin
        n_pass++;
      end
      // Mid-scan start/mask/mode changes must be ignored.
      set_start(d1, (exp_q[k] != 7'b0) ? 1'($urandom_range(0, 1)) : 1'b0);
      chan_mask = 8'($urandom);
      mode_cont = 1'($urandom_range(0, 1));
    end
    if (cont && ch_q.size() != 0) begin
      stop = 1'b1;
      tick();
      o = obs(d1);
      n_total++;
      if (o !== 7'b0) $display("FAIL %s stop: got %b want %b", name, o, 7'b0);
      else            n_pass++;
      stop = 1'b0;
      set_start(d1, 1'b0);
      tick();
      o = obs(d1);
      n_total++;
      if (o !== 7'b0) $display("FAIL %s after stop: got %b want %b", name, o, 7'b0);
      else            n_pass++;
    end
    set_start(d1, 1'b0);
  endtask

  task automatic test_reset();
    n_total++;
    if (obs(0) !== 7'b0) $display("FAIL reset dut4: got %b want %b", obs(0), 7'b0);
    else                 n_pass++;
    n_total++;
    if (obs(1) !== 7'b0) $display("FAIL reset dut1: got %b want %b", obs(1), 7'b0);
    else                 n_pass++;
  endtask

  task automatic test_full_scan();
    run_pass(0, 8'hFF, 1'b0, "full_scan");
  endtask

  task automatic test_sparse();
    run_pass(0, 8'b1010_0100, 1'b0, "sparse");
  endtask

  task automatic test_continuous();
    run_pass(0, 8'h81, 1'b1, "continuous_81");
  endtask

  task automatic test_empty_mask();
    run_pass(0, 8'h00, 1'b0, "empty_single");
    run_pass(0, 8'h00, 1'b1, "empty_cont");
  endtask

  task automatic test_start_stop_idle();
    chan_mask = 8'hFF;
    mode_cont = 1'b0;
    start4    = 1'b1;
    start1    = 1'b1;
    stop      = 1'b1;
    tick();
    start4 = 1'b0;
    start1 = 1'b0;
    stop   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (obs(0) !== 7'b0) $display("FAIL start_stop dut4: got %b want %b", obs(0), 7'b0);
      else                 n_pass++;
      n_total++;
      if (obs(1) !== 7'b0) $display("FAIL start_stop dut1: got %b want %b", obs(1), 7'b0);
      else                 n_pass++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    chan_mask = 8'hFF;
    mode_cont = 1'b0;
    start4    = 1'b1;
    start1    = 1'b1;
    tick();
    start4 = 1'b0;
    start1 = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    n_total++;
    if (obs(0) !== 7'b0) $display("FAIL async_rst dut4: got %b want %b", obs(0), 7'b0);
    else                 n_pass++;
    n_total++;
    if (obs(1) !== 7'b0) $display("FAIL async_rst dut1: got %b want %b", obs(1), 7'b0);
    else                 n_pass++;
    tick();
    rst = 1'b0;
    tick();
    run_pass(0, 8'h10, 1'b0, "post_rst_ch4");
  endtask

  task automatic test_dwell1();
    run_pass(1, 8'h10, 1'b0, "dwell1_ch4");
    run_pass(1, 8'hFF, 1'b0, "dwell1_full");
    run_pass(1, 8'h08, 1'b1, "dwell1_single_cont");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      run_pass(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "random");
  endtask

  initial begin
    rst       = 1'b1;
    start4    = 1'b0;
    start1    = 1'b0;
    stop      = 1'b0;
    mode_cont = 1'b0;
    chan_mask = 8'h00;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_full_scan();
    test_sparse();
    test_continuous();
    test_empty_mask();
    test_start_stop_idle();
    test_async_reset();
    test_dwell1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
